// File: rtl/hamming_pkg.sv
// Shared constants, FSM state type and parity helper for the Hamming(15,11) receive path.
package hamming_pkg;

  localparam int CW_W   = 16;
  localparam int DATA_W = 11;
  localparam int CNT_W  = 4;

  // Hamming parity-bit positions within the 15-bit code (bit 0 of cw_out is overall parity).
  localparam int PAR_POS_1 = 1;
  localparam int PAR_POS_2 = 2;
  localparam int PAR_POS_4 = 4;
  localparam int PAR_POS_8 = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  function automatic logic overall_parity(input logic [CW_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/hamming_rx_holdreg.sv
// Codeword holding register with valid/ack handshake, overrun pulse and optional parity flag.
// Overall-parity check is built only when HAMMING_RX_PARITY_EN is defined.
module hamming_rx_holdreg
  import hamming_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            load_i,
  input  logic [CW_W-1:0] word_i,
  input  logic            ack_i,
  output logic [CW_W-1:0] cw_o,
  output logic            cw_valid_o,
  output logic            overrun_o,
  output logic            par_err_o
);

  logic [CW_W-1:0] cw_q;
  logic            cw_valid_q;
  logic            overrun_q;
  logic            accept;

  // A finishing frame is taken if the register is empty or being emptied this same edge.
  assign accept = load_i && (!cw_valid_q || ack_i);

  // NOTE: reset is synchronous and active-low, so it sits inside the clocked branch, not the sensitivity list.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cw_q       <= '0;
      cw_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (accept) begin
        cw_q       <= word_i;
        cw_valid_q <= 1'b1;
      end else if (load_i) begin
        overrun_q <= 1'b1;
      end else if (ack_i) begin
        cw_valid_q <= 1'b0;
      end
    end
  end

`ifdef HAMMING_RX_PARITY_EN
  logic par_err_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      par_err_q <= 1'b0;
    end else if (accept) begin
      par_err_q <= overall_parity(word_i);
    end else if (!load_i && ack_i) begin
      par_err_q <= 1'b0;
    end
  end

  assign par_err_o = par_err_q;
`else
  assign par_err_o = 1'b0;
`endif

  assign cw_o       = cw_q;
  assign cw_valid_o = cw_valid_q;
  assign overrun_o  = overrun_q;

endmodule

// File: rtl/hamming_rx_deser.sv
// Serial-to-parallel deserializer framing 16-bit Hamming codewords for the decoder.
// Optional overall-parity flag enabled by HAMMING_RX_PARITY_EN (see hamming_rx_holdreg).
module hamming_rx_deser
  import hamming_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ser_in,
  input  logic            ser_valid,
  input  logic            sof,
  output logic [CW_W-1:0] cw_out,
  output logic            cw_valid,
  input  logic            cw_ack,
  output logic            overrun,
  output logic            frame_abort,
  output logic            par_err
);

  state_e           state_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic [CW_W-1:0]  shift_q;
  logic [CW_W-1:0]  shift_d;
  logic [CW_W-1:0]  shift_base;
  logic             frame_abort_q;
  logic             frame_done;

  // A sof bit restarts from an empty register so no partial-frame bits survive.
  assign shift_base = sof ? '0 : shift_q;
  assign shift_d    = MSB_FIRST ? {shift_base[CW_W-2:0], ser_in}
                                : {ser_in, shift_base[CW_W-1:1]};

  assign frame_done = ser_valid && !sof && (state_q == SHIFT)
                      && (bit_cnt_q == CNT_W'(CW_W - 1));

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      frame_abort_q <= 1'b0;
    end else begin
      frame_abort_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ser_valid && sof) begin
            state_q   <= SHIFT;
            bit_cnt_q <= CNT_W'(1);
            shift_q   <= shift_d;
          end
        end
        SHIFT: begin
          if (ser_valid) begin
            shift_q <= shift_d;
            if (sof) begin
              frame_abort_q <= 1'b1;
              bit_cnt_q     <= CNT_W'(1);
            end else begin
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
              if (frame_done) state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  hamming_rx_holdreg u_holdreg (
    .clk        (clk),
    .reset      (reset),
    .load_i     (frame_done),
    .word_i     (shift_d),
    .ack_i      (cw_ack),
    .cw_o       (cw_out),
    .cw_valid_o (cw_valid),
    .overrun_o  (overrun),
    .par_err_o  (par_err)
  );

  assign frame_abort = frame_abort_q;

endmodule

// File: tb/tb_hamming_rx_deser.sv
// Scoreboard bench for hamming_rx_deser (MSB_FIRST=1); parity expectations follow HAMMING_RX_PARITY_EN.
module tb_hamming_rx_deser;

  typedef struct {
    logic [15:0] word;
    logic        valid;
    logic        ovr;
    logic        par;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        ser_in;
  logic        ser_valid;
  logic        sof;
  logic [15:0] cw_out;
  logic        cw_valid;
  logic        cw_ack;
  logic        overrun;
  logic        frame_abort;
  logic        par_err;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   ov_cnt = 0;
  int   fa_cnt = 0;

  hamming_rx_deser #(.MSB_FIRST(1'b1)) dut (
    .clk         (clk),
    .reset       (reset),
    .ser_in      (ser_in),
    .ser_valid   (ser_valid),
    .sof         (sof),
    .cw_out      (cw_out),
    .cw_valid    (cw_valid),
    .cw_ack      (cw_ack),
    .overrun     (overrun),
    .frame_abort (frame_abort),
    .par_err     (par_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  function automatic logic exp_par(input logic [15:0] w);
`ifdef HAMMING_RX_PARITY_EN
    return ^w;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick(input logic s_in, input logic s_v, input logic s_sof, input logic ack);
    @(negedge clk);
    ser_in    = s_in;
    ser_valid = s_v;
    sof       = s_sof;
    cw_ack    = ack;
    @(posedge clk);
    #1;
    if (overrun === 1'b1) ov_cnt++;
    if (frame_abort === 1'b1) fa_cnt++;
  endtask

  task automatic idle(input logic ack);
    tick(1'b0, 1'b0, 1'b0, ack);
  endtask

  task automatic send_frame(input string tag, input logic [15:0] w, input logic ack_last,
                            input exp_t e);
    exp_t got;
    for (int i = 0; i < 15; i++) tick(w[15-i], 1'b1, (i == 0), 1'b0);
    sb_q.push_back(e);
    tick(w[0], 1'b1, 1'b0, ack_last);
    got = sb_q.pop_front();
    check({tag, ".word"},  32'(cw_out),   32'(got.word));
    check({tag, ".valid"}, 32'(cw_valid), 32'(got.valid));
    check({tag, ".ovr"},   32'(overrun),  32'(got.ovr));
    check({tag, ".par"},   32'(par_err),  32'(got.par));
  endtask

  initial begin
    ser_in = 1'b0; ser_valid = 1'b0; sof = 1'b0; cw_ack = 1'b0;
    reset = 1'b0;

    // Reset with busy inputs: all of them must be ignored.
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b1, 1'b1);
    check("rst.cw_out",   32'(cw_out),      32'h0);
    check("rst.cw_valid", 32'(cw_valid),    32'h0);
    check("rst.overrun",  32'(overrun),     32'h0);
    check("rst.abort",    32'(frame_abort), 32'h0);
    check("rst.par",      32'(par_err),     32'h0);
    reset = 1'b1;
    idle(1'b0);
    check("post_rst.cw_valid", 32'(cw_valid), 32'h0);

    // Basic frame, held without ack.
    send_frame("f1d8a", 16'h1D8A, 1'b0, exp_t'{16'h1D8A, 1'b1, 1'b0, exp_par(16'h1D8A)});
    for (int i = 0; i < 3; i++) idle(1'b0);
    check("hold.cw_valid", 32'(cw_valid), 32'h1);
    check("hold.cw_out",   32'(cw_out),   32'h1D8A);

    // Second frame while full: dropped, single overrun pulse.
    ov_cnt = 0;
    send_frame("ovr", 16'hF032, 1'b0, exp_t'{16'h1D8A, 1'b1, 1'b1, exp_par(16'h1D8A)});
    idle(1'b0);
    check("ovr.pulses",   ov_cnt,         1);
    check("ovr.clear",    32'(overrun),   32'h0);
    check("ovr.cw_out",   32'(cw_out),    32'h1D8A);

    // Completion coinciding with ack: replace, stay valid, no overrun.
    ov_cnt = 0;
    send_frame("ackcoin", 16'h935E, 1'b1, exp_t'{16'h935E, 1'b1, 1'b0, exp_par(16'h935E)});
    idle(1'b0);
    check("ackcoin.ovr_pulses", ov_cnt,       0);
    check("ackcoin.hold",       32'(cw_out),  32'h935E);

    idle(1'b1);
    check("ack.cw_valid", 32'(cw_valid), 32'h0);
    check("ack.par",      32'(par_err),  32'h0);
    idle(1'b1);
    check("ack_empty.cw_valid", 32'(cw_valid), 32'h0);
    check("ack_empty.overrun",  32'(overrun),  32'h0);

    // Abort after 7 bits, then a full all-zero frame.
    fa_cnt = 0;
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b1, 1'b0, 1'b0);
    check("abort.before", fa_cnt, 0);
    send_frame("abort", 16'h0000, 1'b0, exp_t'{16'h0000, 1'b1, 1'b0, 1'b0});
    idle(1'b0);
    check("abort.pulses", fa_cnt, 1);
    idle(1'b1);

    // Reset mid-frame with a held word.
    send_frame("pre_rst", 16'h1234, 1'b0, exp_t'{16'h1234, 1'b1, 1'b0, exp_par(16'h1234)});
    begin
      logic [15:0] w;
      w = 16'hABCD;
      for (int i = 0; i < 9; i++) tick(w[15-i], 1'b1, (i == 0), 1'b0);
    end
    reset = 1'b0;
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    check("midrst.cw_valid", 32'(cw_valid),    32'h0);
    check("midrst.cw_out",   32'(cw_out),      32'h0);
    check("midrst.par",      32'(par_err),     32'h0);
    check("midrst.abort",    32'(frame_abort), 32'h0);
    reset = 1'b1;
    for (int i = 0; i < 7; i++) tick(1'b1, 1'b1, 1'b0, 1'b0);
    check("midrst.nosof_ignored", 32'(cw_valid), 32'h0);
    fa_cnt = 0;
    send_frame("post_midrst", 16'h5A5A, 1'b0, exp_t'{16'h5A5A, 1'b1, 1'b0, exp_par(16'h5A5A)});
    check("post_midrst.no_abort", fa_cnt, 0);
    idle(1'b1);

    // Parity flag: odd and even words.
    send_frame("par01", 16'h0001, 1'b0, exp_t'{16'h0001, 1'b1, 1'b0, exp_par(16'h0001)});
    idle(1'b1);
    send_frame("par03", 16'h0003, 1'b0, exp_t'{16'h0003, 1'b1, 1'b0, 1'b0});
    idle(1'b1);
    check("end.cw_valid", 32'(cw_valid), 32'h0);
    check("end.sb_empty", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hamming_rx_deser.md
HAMMING_RX_DESER -- requirements
Module: hamming_rx_deser

Interface
REQ-001 Parameter: MSB_FIRST, default 1, meaning 1 = first serial bit of a frame lands in cw_out[15]; 0 = first bit lands in cw_out[0].
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  reset, synchronous, active-low.
REQ-004 ser_in  input  1  received serial data bit.
REQ-005 ser_valid  input  1  ser_in valid this cycle; bits with ser_valid=0 are ignored.
REQ-006 sof  input  1  start-of-frame; meaningful only when ser_valid=1; marks the first bit of a 16-bit codeword.
REQ-007 cw_out  output  16  assembled codeword to the Hamming(15,11) decoder; bit[0] = overall parity, bits[15:1] = Hamming positions 15..1.
REQ-008 cw_valid  output  1  holding register full; drives decoder dec_ready.
REQ-009 cw_ack  input  1  decoder consumed the word (driven from dec_done).
REQ-010 overrun  output  1  one-cycle pulse: a complete frame was dropped because the holding register was full.
REQ-011 frame_abort  output  1  one-cycle pulse: sof arrived while a frame was partly shifted.
REQ-012 par_err  output  1  overall-parity mismatch flag for the word in cw_out (REQ-027).

Function
REQ-013 FSM states SHALL be IDLE and SHIFT.
- IDLE -> SHIFT on ser_valid=1 and sof=1; that bit is frame bit 0 and bit_cnt becomes 1.
- IDLE ignores ser_valid=1 with sof=0.
REQ-014 In SHIFT, each ser_valid=1 cycle SHALL shift ser_in into a 16-bit shift register and increment the 4-bit bit_cnt.
REQ-015 On the 16th valid bit (bit_cnt=15 on entry), SHALL return to IDLE and bit_cnt SHALL wrap to 0.
REQ-016 sof=1 with ser_valid=1 while in SHIFT SHALL discard the partial frame, pulse frame_abort for one cycle, and restart with this bit as bit 0 (stay in SHIFT, bit_cnt=1).
REQ-017 Frame completion at edge N with the holding register empty SHALL load cw_out and set cw_valid=1 from edge N; latency is 0 cycles after the last bit's edge.
REQ-018 cw_valid SHALL stay 1 and cw_out SHALL stay stable until cw_ack=1 is sampled. cw_valid SHALL clear on that edge unless REQ-019 applies.
REQ-019 Completion and cw_ack=1 in the same cycle SHALL load the new word, keep cw_valid=1, and produce no overrun.
REQ-020 Completion while cw_valid=1 and cw_ack=0 SHALL drop the new frame, keep the held word, and pulse overrun for one cycle.
REQ-021 cw_ack=1 while cw_valid=0 SHALL be ignored.
REQ-022 The shift register and holding register SHALL be independent, so shifting continues while a word is held.

Reset
REQ-023 reset=0 at a clock edge SHALL force IDLE, bit_cnt=0, shift register=0, cw_out=0, cw_valid=0, overrun=0, frame_abort=0, par_err=0.
REQ-024 Reset mid-frame or with a held word SHALL discard both; the first valid sof after release starts a new frame.
REQ-025 Inputs SHALL be ignored during every cycle that reset=0.

Configuration
REQ-026 Macro HAMMING_RX_PARITY_EN selects the overall-parity check.
REQ-027 With HAMMING_RX_PARITY_EN defined:
- par_err SHALL load together with cw_out.
- par_err SHALL equal the XOR of all 16 bits of the loaded word (even parity expected).
- par_err SHALL hold while cw_valid=1 and clear when the word is acknowledged without replacement.
REQ-028 Without HAMMING_RX_PARITY_EN: par_err SHALL be tied to 0 and no parity logic SHALL be synthesized.

Structure
REQ-029 Shared package hamming_pkg SHALL hold:
- CW_W=16 and DATA_W=11.
- The FSM state typedef {IDLE, SHIFT}.
- Parity-position constants 1, 2, 4, 8.
REQ-030 A single sub-module, hamming_rx_holdreg, SHALL implement the holding register, the cw_valid/cw_ack handshake, overrun and par_err; the FSM and shift register stay in the top.

Verification
REQ-031 MSB_FIRST=1; sof plus 16 bits 0001_1101_1000_1010 with cw_ack=0 -> cw_out=16'h1D8A and cw_valid=1 on the 16th bit's edge; cw_valid holds until cw_ack.
REQ-032 Hold 16'h1D8A; send a second frame 16'hF032 with no ack -> overrun pulses once; cw_out stays 16'h1D8A.
REQ-033 Assert cw_ack in the same cycle as the last bit of frame 16'h935E -> cw_out=16'h935E, cw_valid stays 1, overrun=0.
REQ-034 sof after 7 bits, then 16 bits of 16'h0000 -> frame_abort pulses once; cw_out=16'h0000.
REQ-035 Assert reset=0 mid-frame (bit 9) with a held word -> next edge: cw_valid=0, cw_out=0, IDLE; a non-sof bit afterwards is ignored.
REQ-036 With HAMMING_RX_PARITY_EN: frame 16'h0001 -> par_err=1; frame 16'h0003 -> par_err=0. Without the macro: par_err=0 always.
